// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative radix-2 shift-add multiplier with writeback sequencer
// for MUL (low word only), UMULL and SMULL. Holds the controller off via Busy and
// emits one or two register writes under a WbReady handshake.
module mul_sequencer #(
    parameter int WIDTH     = 32,
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Cancel,
    input  logic [1:0]       MulOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       RdLo,
    input  logic [3:0]       RdHi,
    input  logic             WbReady,
    output logic             Busy,
    output logic             WbWe,
    output logic [3:0]       WbAddr,
    output logic [WIDTH-1:0] WbData,
    output logic             WbHi,
    output logic             Done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPUTE,
        S_FIX,
        S_WB_LO,
        S_WB_HI
    } state_t;

    state_t           state, nxt;
    logic [WIDTH-1:0] acc;      // high half of the running product
    logic [WIDTH-1:0] mplr;     // multiplier, low product bits shift in from the top
    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    cnt;
    logic             sign;
    logic             lo_only;  // MUL: only the low word is written back
    logic [3:0]       rd_lo, rd_hi;

    logic             smull;
    logic             zero_op;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   sum;

    // Operand conditioning at acceptance: SMULL works on magnitudes, sign restored in FIX
    always_comb begin
        smull   = (MulOp == 2'b10);
        abs_a   = (smull && SrcA[WIDTH-1]) ? -SrcA : SrcA;
        abs_b   = (smull && SrcB[WIDTH-1]) ? -SrcB : SrcB;
        zero_op = ZERO_SKIP && ((SrcA == '0) || (SrcB == '0));
        sum     = {1'b0, acc} + {1'b0, (mplr[0] ? mcand : {WIDTH{1'b0}})};
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    // Next-state logic; Cancel overrides everything, including a Start in IDLE
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (Start) nxt = zero_op ? S_FIX : S_COMPUTE;
            S_COMPUTE: if (cnt == '0) nxt = S_FIX;
            S_FIX:     nxt = S_WB_LO;
            S_WB_LO:   if (WbReady) nxt = lo_only ? S_IDLE : S_WB_HI;
            S_WB_HI:   if (WbReady) nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
        if (Cancel) nxt = S_IDLE;
    end

    // Datapath: capture, shift-add iteration, final sign fix
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            mplr    <= '0;
            mcand   <= '0;
            cnt     <= '0;
            sign    <= 1'b0;
            lo_only <= 1'b0;
            rd_lo   <= '0;
            rd_hi   <= '0;
        end else if (!Cancel) begin
            case (state)
                S_IDLE: if (Start) begin
                    acc     <= '0;
                    mcand   <= abs_a;
                    cnt     <= CW'(WIDTH - 1);
                    lo_only <= (MulOp == 2'b00);
                    rd_lo   <= RdLo;
                    rd_hi   <= RdHi;
                    if (zero_op) begin
                        mplr <= '0;
                        sign <= 1'b0;
                    end else begin
                        mplr <= abs_b;
                        sign <= smull && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                    end
                end
                S_COMPUTE: begin
                    acc  <= sum[WIDTH:1];
                    mplr <= {sum[0], mplr[WIDTH-1:1]};
                    cnt  <= cnt - 1'b1;
                end
                S_FIX: if (sign) {acc, mplr} <= -{acc, mplr};
                default: ;
            endcase
        end
    end

    // Outputs: strobes from state and WbReady, address/data muxed from held registers
    always_comb begin
        Busy   = (state != S_IDLE);
        WbWe   = 1'b0;
        Done   = 1'b0;
        WbAddr = '0;
        WbData = '0;
        WbHi   = 1'b0;
        case (state)
            S_WB_LO: begin
                WbWe   = WbReady && !Cancel;
                Done   = WbReady && !Cancel && lo_only;
                WbAddr = rd_lo;
                WbData = mplr;
            end
            S_WB_HI: begin
                WbWe   = WbReady && !Cancel;
                Done   = WbReady && !Cancel;
                WbAddr = rd_hi;
                WbData = acc;
                WbHi   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: stimulus pushes expected writes computed with
// plain 64-bit arithmetic, a negedge monitor pops and compares each observed write.
module tb_mul_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         Start = 1'b0, Cancel = 1'b0, WbReady = 1'b1;
    logic [1:0]   MulOp = '0;
    logic [W-1:0] SrcA = '0, SrcB = '0;
    logic [3:0]   RdLo = '0, RdHi = '0;
    logic         Busy, WbWe, WbHi, Done;
    logic [3:0]   WbAddr;
    logic [W-1:0] WbData;

    mul_sequencer #(.WIDTH(W), .ZERO_SKIP(1'b1)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Cancel(Cancel), .MulOp(MulOp),
        .SrcA(SrcA), .SrcB(SrcB), .RdLo(RdLo), .RdHi(RdHi), .WbReady(WbReady),
        .Busy(Busy), .WbWe(WbWe), .WbAddr(WbAddr), .WbData(WbData), .WbHi(WbHi),
        .Done(Done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]   addr;
        logic [W-1:0] data;
        bit           hi;
        bit           done;
        int           at;    // expected cycle of the write, -1 = untimed
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference product straight from the operation's arithmetic meaning
    function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (op == 2'b10) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
        end
        ua = a;
        ub = b;
        return ua * ub;
    endfunction

    task automatic push_exp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] rl, input logic [3:0] rh, input int lo_at);
        logic [63:0] p;
        wb_t e;
        p = model(op, a, b);
        e.addr = rl; e.data = p[31:0]; e.hi = 1'b0; e.done = (op == 2'b00); e.at = lo_at;
        exp_q.push_back(e);
        if (op != 2'b00) begin
            e.addr = rh; e.data = p[63:32]; e.hi = 1'b1; e.done = 1'b1;
            e.at = (lo_at < 0) ? -1 : lo_at + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one accepting edge, then scramble the operand inputs
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] rl, input logic [3:0] rh);
        MulOp = op; SrcA = a; SrcB = b; RdLo = rl; RdHi = rh; Start = 1'b1;
        tick();
        Start = 1'b0;
        SrcA = $urandom; SrcB = $urandom; RdLo = 4'($urandom); RdHi = 4'($urandom);
    endtask

    task automatic wait_idle(input bit rnd);
        int n = 0;
        while (Busy && n < 400) begin
            if (rnd) WbReady = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        WbReady = 1'b1;
        chk("idle_reached", {63'd0, Busy}, 64'd0);
    endtask

    // Monitor: every observed write must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (Done && !WbWe) chk("done_without_write", 64'd1, 64'd0);
            if (WbWe) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {60'd0, WbAddr}, 64'hFFFF);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    chk("wb_addr", {60'd0, WbAddr}, {60'd0, e.addr});
                    chk("wb_data", {32'd0, WbData}, {32'd0, e.data});
                    chk("wb_hi",   {63'd0, WbHi},   {63'd0, e.hi});
                    chk("wb_done", {63'd0, Done},   {63'd0, e.done});
                    if (e.at >= 0) chk("wb_cycle", 64'(cyc), 64'(e.at));
                end
            end
        end
    end

    initial begin
        int c;
        logic [1:0]   op;
        logic [W-1:0] a, b;

        // Reset state
        tick(); tick();
        chk("rst_busy",   {63'd0, Busy},   64'd0);
        chk("rst_wbwe",   {63'd0, WbWe},   64'd0);
        chk("rst_wbaddr", {60'd0, WbAddr}, 64'd0);
        chk("rst_wbdata", {32'd0, WbData}, 64'd0);
        chk("rst_wbhi",   {63'd0, WbHi},   64'd0);
        chk("rst_done",   {63'd0, Done},   64'd0);
        reset = 1'b0;
        tick();

        // Full-width UMULL, timed: low at k+34, high at k+35
        c = cyc; push_exp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 4'd4, c + W + 2);
        start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 4'd4);
        chk("busy_after_start", {63'd0, Busy}, 64'd1);
        wait_idle(1'b0);

        // SMULL signs, back-to-back with the previous Done
        c = cyc; push_exp(2'b10, -32'sd3, 32'sd7, 4'd2, 4'd3, c + W + 2);
        start_op(2'b10, -32'sd3, 32'sd7, 4'd2, 4'd3);
        wait_idle(1'b0);
        c = cyc; push_exp(2'b10, 32'h80000000, 32'h80000000, 4'd7, 4'd8, c + W + 2);
        start_op(2'b10, 32'h80000000, 32'h80000000, 4'd7, 4'd8);
        wait_idle(1'b0);
        c = cyc; push_exp(2'b10, 32'h7FFFFFFF, 32'h80000000, 4'd9, 4'd10, c + W + 2);
        start_op(2'b10, 32'h7FFFFFFF, 32'h80000000, 4'd9, 4'd10);
        wait_idle(1'b0);

        // MUL: single low write carrying Done
        c = cyc; push_exp(2'b00, 32'h12345678, 32'h10, 4'd5, 4'd6, c + W + 2);
        start_op(2'b00, 32'h12345678, 32'h10, 4'd5, 4'd6);
        wait_idle(1'b0);

        // Zero skip: writes at k+2, k+3, Busy low at k+4
        c = cyc; push_exp(2'b01, 32'h0, 32'hDEADBEEF, 4'd11, 4'd12, c + 2);
        start_op(2'b01, 32'h0, 32'hDEADBEEF, 4'd11, 4'd12);
        while (cyc < c + 3) tick();
        chk("zs_busy_k3", {63'd0, Busy}, 64'd1);
        tick();
        chk("zs_busy_k4", {63'd0, Busy}, 64'd0);
        c = cyc; push_exp(2'b10, 32'hFFFFFFF0, 32'h0, 4'd13, 4'd14, c + 2);
        start_op(2'b10, 32'hFFFFFFF0, 32'h0, 4'd13, 4'd14);
        wait_idle(1'b0);

        // WbReady held low 5 cycles in WB_LO: outputs held, write on the 6th
        WbReady = 1'b0;
        c = cyc; push_exp(2'b01, 32'hCAFEF00D, 32'h31415926, 4'd5, 4'd6, c + W + 7);
        start_op(2'b01, 32'hCAFEF00D, 32'h31415926, 4'd5, 4'd6);
        while (cyc < c + W + 2) tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_wbwe",   {63'd0, WbWe},   64'd0);
            chk("stall_wbaddr", {60'd0, WbAddr}, 64'd5);
            chk("stall_wbdata", {32'd0, WbData}, {32'd0, model(2'b01, 32'hCAFEF00D, 32'h31415926) & 64'hFFFFFFFF});
            chk("stall_wbhi",   {63'd0, WbHi},   64'd0);
            tick();
        end
        WbReady = 1'b1;
        wait_idle(1'b0);

        // Start while Busy is ignored; the in-flight result must be unchanged
        c = cyc; push_exp(2'b01, 32'h00010003, 32'h00020005, 4'd3, 4'd15, c + W + 2);
        start_op(2'b01, 32'h00010003, 32'h00020005, 4'd3, 4'd15);
        repeat (4) tick();
        MulOp = 2'b10; SrcA = 32'h55555555; SrcB = 32'h99999999; Start = 1'b1;
        repeat (3) tick();
        Start = 1'b0;
        wait_idle(1'b0);
        repeat (3) tick();
        chk("no_queued_start", {63'd0, Busy}, 64'd0);

        // Cancel at COMPUTE cycle 10: idle next edge, no writes afterwards
        c = cyc;
        start_op(2'b01, 32'h87654321, 32'h0F0F0F0F, 4'd1, 4'd2);
        while (cyc < c + 10) tick();
        chk("cancel_pre_busy", {63'd0, Busy}, 64'd1);
        Cancel = 1'b1;
        tick();
        Cancel = 1'b0;
        chk("cancel_busy", {63'd0, Busy}, 64'd0);
        // Cancel beats Start in IDLE
        MulOp = 2'b01; SrcA = 32'h3; SrcB = 32'h5; Start = 1'b1; Cancel = 1'b1;
        tick();
        Start = 1'b0; Cancel = 1'b0;
        chk("cancel_beats_start", {63'd0, Busy}, 64'd0);
        repeat (40) tick();

        // Reset while stalled in WB_LO clears outputs
        WbReady = 1'b0;
        c = cyc;
        start_op(2'b01, 32'h11111111, 32'h22222222, 4'd9, 4'd10);
        while (cyc < c + W + 3) tick();
        chk("midreset_pre_addr", {60'd0, WbAddr}, 64'd9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        WbReady = 1'b1;
        chk("midreset_busy",   {63'd0, Busy},   64'd0);
        chk("midreset_wbdata", {32'd0, WbData}, 64'd0);
        chk("midreset_wbaddr", {60'd0, WbAddr}, 64'd0);
        repeat (5) tick();

        // Randomized ops with random WbReady backpressure
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: a = '0;
                1: b = '0;
                2: a = 32'h80000000;
                3: b = 32'hFFFFFFFF;
                default: ;
            endcase
            push_exp(op, a, b, 4'($urandom), 4'($urandom), -1);
            start_op(op, a, b, exp_q[exp_q.size() - ((op == 2'b00) ? 1 : 2)].addr,
                     exp_q[exp_q.size() - 1].addr);
            wait_idle(1'b1);
        end

        repeat (5) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
